onehot_decoder_seq: RTL and testbench
=====================================

Name: onehot_decoder_seq

Overview:
- Sequenced 3-to-8 one-hot decoder. It is the inverse of the team's 8-to-3 priority encoder and uses the same bit mapping: code 0 -> 8'b10000000, code 7 -> 8'b00000001.
- Accepts index codes over a valid/ready interface and buffers them in a small FIFO.
- Drives each decoded one-hot pattern on the output for a programmable number of cycles.
- Feeds select/strobe lines downstream, for example a one-hot lane enable.

Parameters:
- HOLD_CYCLES, 4: cycles each decoded pattern is held; legal range >= 1.
- FIFO_DEPTH, 4: input buffer entries; power of 2, >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  block can accept a code this cycle
- in_code  input  3  index to decode
- d  output  8  registered one-hot output; all-zero when idle
- d_valid  output  1  d carries a decoded pattern
- busy  output  1  FIFO not empty OR state == DRIVE
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values:
  - d = 0, d_valid = 0, busy = 0, fifo_count = 0.
  - FSM = IDLE, hold counter = 0, FIFO pointers = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.
- Decode: d[7-k] = 1 for code k; all other bits 0. d is never multi-hot.
- Input handshake:
  - in_ready = !rst && (fifo_count < FIFO_DEPTH). It depends on count only, so it is deasserted when the FIFO is full even if a pop occurs in the same cycle.
  - A push occurs when in_valid && in_ready.
  - in_code is ignored when the push does not occur.
- FIFO: circular buffer with wrap-around pointers. A simultaneous push and pop leaves fifo_count unchanged. There is no bypass: a code always passes through the FIFO.
- FSM states:
  - IDLE:
    - If FIFO is non-empty: pop the head, load d = decode(head), set d_valid = 1, load counter = HOLD_CYCLES-1, go to DRIVE.
    - Otherwise: d = 0, d_valid = 0.
  - DRIVE:
    - If counter != 0: decrement counter; d and d_valid are held.
    - If counter == 0 and FIFO is non-empty: pop the next code, load d, reload counter, stay in DRIVE. Patterns are back-to-back with no gap cycle.
    - If counter == 0 and FIFO is empty: d = 0, d_valid = 0, go to IDLE.
- Latency:
  - A code pushed at edge N into an empty FIFO while IDLE is popped at edge N+1. d/d_valid are visible from edge N+1 for exactly HOLD_CYCLES cycles.
  - Each pattern holds for exactly HOLD_CYCLES cycles.
- HOLD_CYCLES = 1: the output can change pattern every cycle. Sustained throughput is 1 code/cycle.
- Reset mid-operation (rst asserted in any state): at that edge, d = 0, d_valid = 0, the FIFO is flushed, and the FSM returns to IDLE. Pending codes are discarded.
- in_valid asserted during rst: no push.

Test Plan:
1. Reset: hold rst 3 cycles with in_valid = 1, in_code = 5.
   -> in_ready = 0, d = 0, d_valid = 0, fifo_count = 0 throughout; no push occurs.
2. Single code: push code 0 at edge N (HOLD_CYCLES = 4).
   -> d = 8'b10000000, d_valid = 1 for cycles N+1..N+4; d = 0, d_valid = 0, busy = 0 at N+5.
3. Burst: push codes 7, 3, 1 back-to-back.
   -> d = 00000001 (4 cycles), then 00010000 (4), then 01000000 (4), no gaps; fifo_count peaks at 2.
4. Backpressure: push 6 codes on consecutive cycles while the first is held (FIFO_DEPTH = 4).
   -> in_ready drops when fifo_count = 4; rejected codes are not output; accepted codes appear in order; pointer wrap is exercised by a second burst.
5. Reset mid-drive: assert rst during cycle 2 of a pattern with 2 codes queued.
   -> next cycle d = 0, d_valid = 0, fifo_count = 0; the queued codes never appear.
6. HOLD_CYCLES = 1: stream codes 0..7 continuously.
   -> d walks 10000000 down to 00000001 one per cycle; in_ready stays 1; fifo_count <= 1.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 one-hot decoder: codes are queued in a small FIFO and each
// decoded pattern (code k -> bit 7-k) is held on d for HOLD_CYCLES cycles.
module onehot_decoder_seq #(
   parameter int HOLD_CYCLES = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [2:0]                      in_code,
   output logic [7:0]                      d,
   output logic                            d_valid,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = PW + 1;
   localparam int CW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [7:0]      d_nxt;
   logic            d_valid_nxt;
   logic [2:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop, nonempty;

   function automatic logic [7:0] decode(input logic [2:0] code);
      return 8'b1000_0000 >> code;
   endfunction

   assign in_ready = !rst && (fifo_count < CNTW'(FIFO_DEPTH));
   assign push     = in_valid && in_ready;
   assign nonempty = (fifo_count != '0);
   assign busy     = nonempty || (state == DRIVE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_code;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         state      <= IDLE;
         cnt        <= '0;
         d          <= '0;
         d_valid    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNTW'(1);
            2'b01:   fifo_count <= fifo_count - CNTW'(1);
            default: fifo_count <= fifo_count;
         endcase
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         d       <= d_nxt;
         d_valid <= d_valid_nxt;
      end
   end

   // A pop loads the next pattern directly, so back-to-back codes have no gap.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      d_nxt       = d;
      d_valid_nxt = d_valid;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (nonempty) begin
               pop         = 1'b1;
               d_nxt       = decode(mem[rd_ptr]);
               d_valid_nxt = 1'b1;
               cnt_nxt     = CW'(HOLD_CYCLES - 1);
               state_nxt   = DRIVE;
            end else begin
               d_nxt       = '0;
               d_valid_nxt = 1'b0;
            end
         end
         DRIVE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else if (nonempty) begin
               pop         = 1'b1;
               d_nxt       = decode(mem[rd_ptr]);
               d_valid_nxt = 1'b1;
               cnt_nxt     = CW'(HOLD_CYCLES - 1);
            end else begin
               d_nxt       = '0;
               d_valid_nxt = 1'b0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: directed scenarios plus random traffic on a
// HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance, checked against a queue model.
module tb_onehot_decoder_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1;
   logic [2:0] c0, c1;
   logic       rdy0, rdy1, dv0, dv1, busy0, busy1;
   logic [7:0] d0, d1;
   logic [2:0] cnt0, cnt1;

   int checks   = 0;
   int failures = 0;
   int sel      = 0;   // which instance is being exercised
   int q[$];           // codes waiting in the input buffer
   int cur      = 0;   // code currently shown
   int rem      = 0;   // cycles the current pattern still has to show, 0 = idle

   always #5 clk = ~clk;

   onehot_decoder_seq #(.HOLD_CYCLES(4), .FIFO_DEPTH(4)) u_h4 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_code(c0),
      .d(d0), .d_valid(dv0), .busy(busy0), .fifo_count(cnt0));

   onehot_decoder_seq #(.HOLD_CYCLES(1), .FIFO_DEPTH(4)) u_h1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_code(c1),
      .d(d1), .d_valid(dv1), .busy(busy1), .fifo_count(cnt1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s (hold=%0d) observed=%0h expected=%0h", tag, sel ? 1 : 4, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [2:0] c);
      int h;
      bit take;
      h   = sel ? 1 : 4;
      rst = r;
      if (sel != 0) begin v1 = v; c1 = c; v0 = 1'b0; end
      else          begin v0 = v; c0 = c; v1 = 1'b0; end
      #1;
      chk("in_ready", sel ? rdy1 : rdy0, (!r && q.size() < 4));
      @(posedge clk);
      if (r) begin
         q.delete();
         rem = 0;
      end else begin
         take = v && (q.size() < 4);
         if (rem <= 1 && q.size() > 0) begin
            cur = q.pop_front();
            rem = h;
         end else if (rem > 0) begin
            rem--;
         end
         if (take) q.push_back(int'(c));
      end
      #1;
      chk("d",          sel ? d1 : d0,       (rem > 0) ? (32'h80 >> cur) : 32'h0);
      chk("d_valid",    sel ? dv1 : dv0,     rem > 0);
      chk("busy",       sel ? busy1 : busy0, (rem > 0) || (q.size() > 0));
      chk("fifo_count", sel ? cnt1 : cnt0,   q.size());
   endtask

   initial begin
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; c0 = '0; c1 = '0;

      // reset held with a valid code pending: nothing may be accepted
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd5);

      // single code
      step(1'b0, 1'b1, 3'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0);

      // burst of three
      step(1'b0, 1'b1, 3'd7);
      step(1'b0, 1'b1, 3'd3);
      step(1'b0, 1'b1, 3'd1);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 3'd0);

      // backpressure: six pushes, some rejected, then a second burst wraps pointers
      begin
         logic [2:0] codes [6] = '{3'd2, 3'd4, 3'd6, 3'd5, 3'd3, 3'd0};
         for (int i = 0; i < 6; i++) step(1'b0, 1'b1, codes[i]);
         for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 3'd0);
         for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'(i + 1));
         for (int i = 0; i < 26; i++) step(1'b0, 1'b0, 3'd0);
      end

      // reset in the middle of a pattern with codes queued
      step(1'b0, 1'b1, 3'd1);
      step(1'b0, 1'b1, 3'd2);
      step(1'b0, 1'b1, 3'd3);
      step(1'b1, 1'b0, 3'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'd0);

      // HOLD_CYCLES = 1 streaming
      sel = 1;
      step(1'b1, 1'b0, 3'd0);
      step(1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 3'(k));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0);

      // random traffic on both instances
      for (int s = 0; s < 2; s++) begin
         sel = s;
         step(1'b1, 1'b0, 3'd0);
         for (int i = 0; i < 300; i++)
            step(($urandom % 60) == 0, ($urandom % 3) != 0, 3'($urandom_range(0, 7)));
         for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 3'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
